// File: rtl/deq_stream_reader_if.sv
// deq_stream_reader_if
//   Groups the two handshakes of the stream reader into one bundle.
//   Upstream side : deq_en (strobe to the queue), deq_rdy, deq_msg
//   Downstream side: out_val, out_rdy, out_msg
//   master modport: the reader itself
//   slave modport : the environment (upstream queue and downstream consumer)
interface deq_stream_reader_if #(
  parameter int p_data_width = 32
);
  logic                    deq_en;
  logic                    deq_rdy;
  logic [p_data_width-1:0] deq_msg;
  logic                    out_val;
  logic                    out_rdy;
  logic [p_data_width-1:0] out_msg;

  modport master (
    output deq_en,
    input  deq_rdy,
    input  deq_msg,
    output out_val,
    input  out_rdy,
    output out_msg
  );

  modport slave (
    input  deq_en,
    output deq_rdy,
    output deq_msg,
    input  out_val,
    output out_rdy,
    input  out_msg
  );
endinterface

// File: rtl/deq_stream_reader.sv
// deq_stream_reader
//   Pulls messages out of an upstream queue through its dequeue port and
//   presents them downstream as a valid/ready stream, with a small local
//   circular buffer in between.
// Ports:
//   clk       - single clock, all state updates on the rising edge
//   reset     - asynchronous active-high reset, clears pointers and count
//   flush     - synchronous drop of all locally buffered messages
//   bus       - deq_stream_reader_if.master (deq_en/deq_rdy/deq_msg and
//               out_val/out_rdy/out_msg)
//   occupancy - number of messages currently held locally
module deq_stream_reader #(
  parameter int p_data_width  = 32,
  parameter int p_num_entries = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  deq_stream_reader_if.master                bus,
  output logic [$clog2(p_num_entries):0]     occupancy
);

  localparam int c_ptr_w = $clog2(p_num_entries);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(p_num_entries);

  logic [c_ptr_w-1:0]      wr_ptr;
  logic [c_ptr_w-1:0]      rd_ptr;
  logic [c_cnt_w-1:0]      count;
  logic [p_data_width-1:0] mem [p_num_entries];

  logic full;
  logic push;
  logic pop;

  // Push depends only on upstream readiness, flush and our own fill level,
  // so nothing from the downstream side reaches deq_en combinationally.
  // A full buffer refuses even when a pop is happening in the same cycle.
  // Reset is applied only on the visible strobe; internally a push during
  // reset merely writes storage, which is harmless because the pointers
  // are held at zero.
  assign full         = (count == c_full);
  assign push         = bus.deq_rdy & ~flush & ~full;
  assign pop          = (count != '0) & bus.out_rdy;
  assign bus.deq_en   = push & ~reset;
  assign bus.out_val  = (count != '0);
  assign bus.out_msg  = mem[rd_ptr];
  assign occupancy    = count;

  // Pointer and count bookkeeping. Flush wins over a pop in the same cycle;
  // push is already blocked by flush. Depth is a power of two, so the
  // pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + c_ptr_w'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + c_ptr_w'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + c_cnt_w'(1);
        2'b01:   count <= count - c_cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

  // Message storage is deliberately left out of reset; stale contents are
  // never visible because out_val is low whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.deq_msg;
    end
  end

endmodule

// File: tb/tb_deq_stream_reader.sv
// tb_deq_stream_reader
//   Self-checking bench. The upstream queue and the local buffer are modelled
//   as plain queues: an expected message joins the scoreboard when the model
//   says it is dequeued, and a separate monitor pops and compares whenever
//   the DUT completes an output handshake.
module tb_deq_stream_reader;

  localparam int c_w     = 32;
  localparam int c_depth = 2;

  logic                       clk;
  logic                       reset;
  logic                       flush;
  logic [$clog2(c_depth):0]   occupancy;

  deq_stream_reader_if #(.p_data_width(c_w)) bus ();

  deq_stream_reader #(
    .p_data_width  (c_w),
    .p_num_entries (c_depth)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int received = 0;
  int deq_seen = 0;

  logic [c_w-1:0] up_q[$];
  logic [c_w-1:0] sb_q[$];

  task automatic check_value(input string name, input logic [c_w-1:0] actual,
                             input logic [c_w-1:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge, the model is
  // compared shortly after, and the model state advances for the next edge.
  task automatic apply_stimulus(input bit offer, input bit ordy, input bit fl);
    logic exp_en;
    @(negedge clk);
    bus.deq_rdy = offer && (up_q.size() > 0);
    bus.deq_msg = (up_q.size() > 0) ? up_q[0] : $urandom;
    bus.out_rdy = ordy;
    flush       = fl;
    #1;
    exp_en = bus.deq_rdy && !fl && (sb_q.size() < c_depth);
    check_value("occupancy", c_w'(occupancy), c_w'(sb_q.size()));
    check_value("out_val", c_w'(bus.out_val), c_w'(sb_q.size() != 0));
    check_value("deq_en", c_w'(bus.deq_en), c_w'(exp_en));
    if (bus.deq_en) deq_seen++;
    if (fl) sb_q.delete();
    else if (exp_en) sb_q.push_back(up_q.pop_front());
  endtask

  task automatic check_output();
    logic [c_w-1:0] exp_msg;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL pop_unexpected actual=0x%0h required=none", bus.out_msg);
    end else begin
      exp_msg = sb_q.pop_front();
      check_value("out_msg", bus.out_msg, exp_msg);
      received++;
    end
  endtask

  // Monitor: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    #2;
    if (reset === 1'b0 && flush === 1'b0 && bus.out_val === 1'b1 && bus.out_rdy === 1'b1)
      check_output();
  end

  task automatic drain();
    for (int i = 0; i < 30 && (sb_q.size() > 0 || up_q.size() > 0); i++)
      apply_stimulus(1'b1, 1'b1, 1'b0);
    check_value("drain_empty", c_w'(sb_q.size() + up_q.size()), c_w'(0));
  endtask

  task automatic reset_mid();
    @(negedge clk);
    bus.out_rdy = 1'b0;
    flush       = 1'b0;
    bus.deq_rdy = 1'b1;
    #3 reset = 1'b1;
    #1;
    check_value("rst_out_val", c_w'(bus.out_val), c_w'(0));
    check_value("rst_occupancy", c_w'(occupancy), c_w'(0));
    check_value("rst_deq_en", c_w'(bus.deq_en), c_w'(0));
    sb_q.delete();
    up_q.delete();
    @(negedge clk);
    check_value("rst_hold_deq_en", c_w'(bus.deq_en), c_w'(0));
    bus.deq_rdy = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int base;
    reset       = 1'b1;
    flush       = 1'b0;
    bus.deq_rdy = 1'b1;
    bus.deq_msg = '0;
    bus.out_rdy = 1'b0;

    // Reset state, with upstream offering so a stray strobe would show.
    @(negedge clk);
    @(negedge clk);
    #1;
    check_value("init_deq_en", c_w'(bus.deq_en), c_w'(0));
    check_value("init_out_val", c_w'(bus.out_val), c_w'(0));
    check_value("init_occupancy", c_w'(occupancy), c_w'(0));
    bus.deq_rdy = 1'b0;
    reset = 1'b0;

    // Stream: continuous flow, occupancy settles at 1 with pop+push per edge.
    $display("[TB] stream phase");
    base = received;
    up_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'b1, 1'b0);
    drain();
    check_value("stream_count", c_w'(received - base), c_w'(4));

    // Backpressure: only two dequeues until a pop frees a slot.
    $display("[TB] backpressure phase");
    up_q = '{32'ha1, 32'ha2, 32'ha3, 32'ha4};
    deq_seen = 0;
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 1'b0);
    check_value("bp_deq_count", c_w'(deq_seen), c_w'(2));
    apply_stimulus(1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    drain();

    // Flush with two buffered and out_rdy high: nothing pops.
    $display("[TB] flush phase");
    up_q = '{32'hf1, 32'hf2, 32'hf3};
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0);
    base = received;
    apply_stimulus(1'b1, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_value("flush_no_pop", c_w'(received - base), c_w'(0));
    drain();

    // Reset in the middle of a transfer with two messages buffered.
    $display("[TB] reset phase");
    up_q = '{32'hb1, 32'hb2, 32'hb3};
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0);
    reset_mid();
    base = received;
    up_q = '{32'hc1, 32'hc2};
    drain();
    check_value("post_reset_count", c_w'(received - base), c_w'(2));

    // Wrap-around: ten messages with random handshakes on both sides.
    $display("[TB] wrap phase");
    base = received;
    for (int i = 0; i < 10; i++) up_q.push_back(c_w'(i));
    for (int i = 0; i < 300 && (received - base) < 10; i++)
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    check_value("wrap_count", c_w'(received - base), c_w'(10));

    // Random traffic with random data and occasional flushes.
    $display("[TB] random phase");
    for (int i = 0; i < 20; i++) up_q.push_back($urandom);
    for (int i = 0; i < 120; i++)
      apply_stimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 15) == 0));
    drain();

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
